// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard receiver.
//   PS2_EXT / PS2_BRK    : extended and break prefix bytes
//   PS2_SYS_*            : keyboard system/response codes that never form key events
//   PS2_FRAME_BITS       : start + 8 data + parity + stop
//   ps2_event_t          : one decoded key event {code, brk, ext}
//   is_sys_code()        : true for any system code
package ps2_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;

    localparam logic [7:0] PS2_SYS_ERR0   = 8'h00;
    localparam logic [7:0] PS2_SYS_BAT    = 8'hAA;
    localparam logic [7:0] PS2_SYS_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_SYS_ACK    = 8'hFA;
    localparam logic [7:0] PS2_SYS_RESEND = 8'hFE;
    localparam logic [7:0] PS2_SYS_ERR1   = 8'hFF;

    localparam int PS2_FRAME_BITS = 11;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_event_t;

    function automatic logic is_sys_code(input logic [7:0] b);
        return (b == PS2_SYS_ERR0) || (b == PS2_SYS_BAT)    ||
               (b == PS2_SYS_ECHO) || (b == PS2_SYS_ACK)    ||
               (b == PS2_SYS_RESEND) || (b == PS2_SYS_ERR1);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous first-word-fall-through FIFO for key events.
//   clock, reset  : system clock, asynchronous active-low reset
//   push, push_data : write request and entry; dropped when full unless popped same cycle
//   pop           : consumer takes the head this cycle (ignored when empty)
//   head, valid   : current head entry (zero when empty) and not-empty flag
//   overflow      : sticky, set when an entry was dropped because the FIFO was full
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    assign valid = !empty;
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver producing buffered key events.
//   clock, reset     : system clock, asynchronous active-low reset
//   ps2clk, ps2data  : raw pad signals (synchronised and filtered internally)
//   ev_valid/ev_ready: FWFT handshake for the event FIFO head
//   ev_code/ev_break/ev_ext : head event scancode, release flag, E0 flag
//   overflow         : sticky, an event was dropped on a full FIFO
//   err_pulse        : one cycle per framing, parity or timeout error
//   err_count        : saturating error count
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8,
    parameter int REPORT_MAKE    = 1,
    parameter int ERR_W          = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ps2clk,
    input  logic             ps2data,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [7:0]       ev_code,
    output logic             ev_break,
    output logic             ev_ext,
    output logic             overflow,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int         HALF     = FILTER_LEN / 2;
    localparam int         WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic [FILTER_LEN-1:0] clk_hist;
    logic                  fall_edge;
    logic [0:0]            state;
    logic [3:0]            bit_cnt;
    logic [8:0]            shift;
    logic [WD_W-1:0]       wd_cnt;
    logic                  ext_pend, brk_pend;
    logic                  frame_done, frame_ok, timeout, err;
    logic                  is_ext, is_brk, is_sys, is_key, push;
    logic [7:0]            rx_byte;
    ps2_event_t            push_ev, ev_head;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            dat_s1   <= 1'b0;
            dat_s2   <= 1'b0;
            clk_hist <= '0;
        end else begin
            clk_s1   <= ps2clk;
            clk_s2   <= clk_s1;
            dat_s1   <= ps2data;
            dat_s2   <= dat_s1;
            clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_s2};
        end
    end

    // Bit 0 is the newest sample: a clean high-then-low history marks exactly one falling edge.
    assign fall_edge = (&clk_hist[FILTER_LEN-1:HALF]) && !(|clk_hist[HALF-1:0]);

    // shift[7:0] holds the data byte and shift[8] the parity bit once the stop bit arrives.
    assign rx_byte    = shift[7:0];
    assign frame_done = (state == ST_RECV) && fall_edge && (bit_cnt == STOP_IDX);
    assign frame_ok   = frame_done && (^shift) && dat_s2;
    assign timeout    = (state == ST_RECV) && !fall_edge && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign err        = (frame_done && !frame_ok) || timeout;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            wd_cnt  <= '0;
        end else if (timeout) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            wd_cnt  <= '0;
        end else if (fall_edge) begin
            wd_cnt <= '0;
            if (state == ST_IDLE) begin
                // A high start bit is line noise, not a frame.
                if (!dat_s2) begin
                    state   <= ST_RECV;
                    bit_cnt <= 4'd1;
                end
            end else if (bit_cnt == STOP_IDX) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else begin
                shift   <= {dat_s2, shift[8:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else if (state == ST_RECV) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign is_ext  = frame_ok && (rx_byte == PS2_EXT);
    assign is_brk  = frame_ok && (rx_byte == PS2_BRK);
    assign is_sys  = frame_ok && is_sys_code(rx_byte);
    assign is_key  = frame_ok && !(rx_byte == PS2_EXT) && !(rx_byte == PS2_BRK) && !is_sys_code(rx_byte);
    assign push    = is_key && (brk_pend || (REPORT_MAKE != 0));
    assign push_ev = '{code: rx_byte, brk: brk_pend, ext: ext_pend};

    // Prefix flags live until a key, a system code or any error ends the sequence.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (err || is_sys || is_key) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else if (is_ext) begin
            ext_pend <= 1'b1;
        end else if (is_brk) begin
            brk_pend <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= err;
            if (err && (err_count != '1)) err_count <= err_count + 1'b1;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(ps2_event_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_ev),
        .pop       (ev_ready),
        .head      (ev_head),
        .valid     (ev_valid),
        .overflow  (overflow)
    );

    assign ev_code  = ev_head.code;
    assign ev_break = ev_head.brk;
    assign ev_ext   = ev_head.ext;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: scoreboard bench for ps2_kbd_rx. Two receivers share the PS/2 lines:
// dut_a reports make and break events, dut_b reports break events only.
module tb_ps2_kbd_rx;
    import ps2_pkg::*;

    localparam int TIMEOUT  = 300;
    localparam int DEPTH    = 8;
    localparam int HALF_PER = 20;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ps2clk = 1'b1;
    logic ps2data = 1'b1;
    logic ev_ready_a = 1'b0;
    logic ev_ready_b = 1'b1;

    logic       ev_valid_a, ev_break_a, ev_ext_a, overflow_a, err_pulse_a;
    logic [7:0] ev_code_a, err_count_a;
    logic       ev_valid_b, ev_break_b, ev_ext_b, overflow_b, err_pulse_b;
    logic [7:0] ev_code_b, err_count_b;

    ps2_event_t exp_a[$];
    ps2_event_t exp_b[$];
    int n_checks = 0;
    int n_pass = 0;
    int valid_cycles_a = 0;
    int err_cycles_a = 0;

    always #5 clock = ~clock;

    ps2_kbd_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(DEPTH),
                 .REPORT_MAKE(1), .ERR_W(8)) u_dut_a (
        .clock(clock), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
        .ev_valid(ev_valid_a), .ev_ready(ev_ready_a), .ev_code(ev_code_a),
        .ev_break(ev_break_a), .ev_ext(ev_ext_a), .overflow(overflow_a),
        .err_pulse(err_pulse_a), .err_count(err_count_a));

    ps2_kbd_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(DEPTH),
                 .REPORT_MAKE(0), .ERR_W(8)) u_dut_b (
        .clock(clock), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
        .ev_valid(ev_valid_b), .ev_ready(ev_ready_b), .ev_code(ev_code_b),
        .ev_break(ev_break_b), .ev_ext(ev_ext_b), .overflow(overflow_b),
        .err_pulse(err_pulse_b), .err_count(err_count_b));

    function automatic ps2_event_t mk(input logic [7:0] c, input logic b, input logic e);
        ps2_event_t ev;
        ev.code = c;
        ev.brk  = b;
        ev.ext  = e;
        return ev;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Sends the first nbits of an 11-bit frame; pop_on_stop pulses ev_ready_a for the
    // single cycle in which the stop-bit event is pushed (2 sync flops + half filter).
    task automatic applyStimulus(input logic [7:0] b, input int nbits = 11,
                                 input bit bad_par = 1'b0, input bit bad_stop = 1'b0,
                                 input bit pop_on_stop = 1'b0);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2data = f[i];
            wait_cycles(HALF_PER);
            ps2clk = 1'b0;
            if (pop_on_stop && i == 10) begin
                repeat (6) @(posedge clock);
                #1 ev_ready_a = 1'b1;
                @(posedge clock);
                #1 ev_ready_a = 1'b0;
                wait_cycles(HALF_PER - 7);
            end else begin
                wait_cycles(HALF_PER);
            end
            ps2clk = 1'b1;
        end
        if (nbits == 11) begin
            ps2data = 1'b1;
            wait_cycles(2 * HALF_PER);
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 2000) begin
            @(posedge clock);
            k++;
        end
        #1;
        checkOutput(name, 32'(exp_a.size() + exp_b.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever a consumer handshake completes.
    always @(negedge clock) begin
        if (ev_valid_a) valid_cycles_a++;
        if (err_pulse_a) err_cycles_a++;
        if (ev_valid_a && ev_ready_a) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_a: got %0h, expected no event", {ev_code_a, ev_break_a, ev_ext_a});
            end else begin
                checkOutput("event_a", 32'({ev_code_a, ev_break_a, ev_ext_a}), 32'(exp_a.pop_front()));
            end
        end
        if (ev_valid_b && ev_ready_b) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_b: got %0h, expected no event", {ev_code_b, ev_break_b, ev_ext_b});
            end else begin
                checkOutput("event_b", 32'({ev_code_b, ev_break_b, ev_ext_b}), 32'(exp_b.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        // Reset state
        wait_cycles(5);
        checkOutput("rst_valid_a", 32'(ev_valid_a), 32'd0);
        checkOutput("rst_code_a", 32'(ev_code_a), 32'd0);
        checkOutput("rst_overflow_a", 32'(overflow_a), 32'd0);
        checkOutput("rst_err_count_a", 32'(err_count_a), 32'd0);
        checkOutput("rst_err_pulse_b", 32'(err_pulse_b), 32'd0);
        reset = 1'b1;
        ev_ready_a = 1'b1;
        wait_cycles(50);

        // Single make code with an always-ready consumer
        valid_cycles_a = 0;
        exp_a.push_back(mk(8'h1C, 1'b0, 1'b0));
        applyStimulus(8'h1C);
        wait_drain("t1_drain");
        checkOutput("t1_valid_cycles", 32'(valid_cycles_a), 32'd1);
        checkOutput("t1_err_count", 32'(err_count_a), 32'd0);

        // Prefix decoding; dut_b ignores makes
        exp_a.push_back(mk(8'h75, 1'b0, 1'b0));
        applyStimulus(8'h75);
        exp_a.push_back(mk(8'h75, 1'b1, 1'b1));
        exp_b.push_back(mk(8'h75, 1'b1, 1'b1));
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        exp_a.push_back(mk(8'h74, 1'b0, 1'b1));
        applyStimulus(8'hE0);
        applyStimulus(8'h74);
        applyStimulus(8'hF0);
        applyStimulus(8'hAA);
        exp_a.push_back(mk(8'h1C, 1'b0, 1'b0));
        applyStimulus(8'h1C);
        wait_drain("t2_drain");

        // Parity, stop-bit errors; a bad frame cancels a pending break
        applyStimulus(8'h1C, 11, 1'b1);
        exp_a.push_back(mk(8'h1C, 1'b0, 1'b0));
        applyStimulus(8'h1C);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C, 11, 1'b1);
        exp_a.push_back(mk(8'h1C, 1'b0, 1'b0));
        applyStimulus(8'h1C);
        applyStimulus(8'h1C, 11, 1'b0, 1'b1);
        wait_drain("t3_drain");
        checkOutput("t3_err_count_a", 32'(err_count_a), 32'd3);
        checkOutput("t3_err_count_b", 32'(err_count_b), 32'd3);
        checkOutput("t3_err_pulse_cycles", 32'(err_cycles_a), 32'd3);

        // Watchdog: abort after 5 bits, then a clean frame
        applyStimulus(8'h3C, 5);
        ps2data = 1'b1;
        wait_cycles(TIMEOUT / 2);
        checkOutput("t4_before_timeout", 32'(err_count_a), 32'd3);
        wait_cycles(TIMEOUT);
        checkOutput("t4_err_count", 32'(err_count_a), 32'd4);
        checkOutput("t4_err_pulse_cycles", 32'(err_cycles_a), 32'd4);
        exp_a.push_back(mk(8'h2A, 1'b0, 1'b0));
        applyStimulus(8'h2A);
        wait_drain("t4_drain");
        checkOutput("t4_err_count_after", 32'(err_count_a), 32'd4);

        // Overflow: nine makes into an eight-deep FIFO with no consumer
        ev_ready_a = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            if (i <= DEPTH) exp_a.push_back(mk(8'(i), 1'b0, 1'b0));
            applyStimulus(8'(i));
        end
        checkOutput("t5_valid", 32'(ev_valid_a), 32'd1);
        checkOutput("t5_head", 32'(ev_code_a), 32'h01);
        checkOutput("t5_overflow_a", 32'(overflow_a), 32'd1);
        checkOutput("t5_overflow_b", 32'(overflow_b), 32'd0);
        // Push and pop in the same cycle while full
        exp_a.push_back(mk(8'h0A, 1'b0, 1'b0));
        applyStimulus(8'h0A, 11, 1'b0, 1'b0, 1'b1);
        checkOutput("t5_head_after_pp", 32'(ev_code_a), 32'h02);
        checkOutput("t5_overflow_after_pp", 32'(overflow_a), 32'd1);
        ev_ready_a = 1'b1;
        wait_drain("t5_drain");

        // Reset mid-frame with queued events
        ev_ready_a = 1'b0;
        exp_a.push_back(mk(8'h11, 1'b0, 1'b0));
        applyStimulus(8'h11);
        exp_a.push_back(mk(8'h12, 1'b0, 1'b0));
        applyStimulus(8'h12);
        exp_a.push_back(mk(8'h13, 1'b0, 1'b0));
        applyStimulus(8'h13);
        checkOutput("t6_valid_before", 32'(ev_valid_a), 32'd1);
        applyStimulus(8'h55, 4);
        reset = 1'b0;
        #2;
        checkOutput("t6_valid_in_reset", 32'(ev_valid_a), 32'd0);
        checkOutput("t6_overflow_in_reset", 32'(overflow_a), 32'd0);
        checkOutput("t6_err_count_in_reset", 32'(err_count_a), 32'd0);
        exp_a.delete();
        exp_b.delete();
        ps2data = 1'b1;
        wait_cycles(5);
        reset = 1'b1;
        ev_ready_a = 1'b1;
        wait_cycles(50);
        exp_a.push_back(mk(8'h5A, 1'b1, 1'b0));
        exp_b.push_back(mk(8'h5A, 1'b1, 1'b0));
        applyStimulus(8'hF0);
        applyStimulus(8'h5A);
        exp_a.push_back(mk(8'h1C, 1'b0, 1'b0));
        applyStimulus(8'h1C);
        wait_drain("t6_drain");
        checkOutput("t6_err_count_after", 32'(err_count_a), 32'd0);
        checkOutput("t6_overflow_after", 32'(overflow_a), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver, successor to the single-byte release-code catcher. Filters and edge-detects ps2clk, deframes 11-bit packets, and decodes E0 (extended) and F0 (break) prefixes into full key events. Events carry make/break and extended flags and are buffered in a small FIFO with a valid/ready handshake, so the VGA-side consumer never misses a keystroke. Adds a frame watchdog and an error counter.

Parameters:
FILTER_LEN, 8, ps2clk sample history length (even, >=4); falling edge = oldest half all 1, newest half all 0
TIMEOUT_CYCLES, 50000, idle clock cycles inside a frame before abort (1 ms at 50 MHz)
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
REPORT_MAKE, 1, 1 = enqueue make and break events; 0 = break events only
ERR_W, 8, error counter width

Ports:
clock      in   1      system clock
reset      in   1      asynchronous, active-low reset
ps2clk     in   1      raw PS/2 clock from pad
ps2data    in   1      raw PS/2 data from pad
ev_valid   out  1      FIFO head holds an event
ev_ready   in   1      consumer accepts head this cycle
ev_code    out  8      scancode of head event
ev_break   out  1      head is a key release
ev_ext     out  1      head was E0-prefixed
overflow   out  1      sticky: event dropped because FIFO full
err_pulse  out  1      one-cycle pulse per framing/parity/timeout error
err_count  out  ERR_W  saturating error count

Behaviour:
- Reset (reset=0, async): all outputs 0, FIFO empty, FSM IDLE, prefix flags clear, filter history all 0.
- Input sync: ps2clk and ps2data each pass a 2-flop synchroniser; filtered ps2clk history shifts every cycle; fall_edge is a one-cycle strobe.
- Frame FSM, bit counter 0..10, all sampling on fall_edge using synchronised data:
  IDLE: fall_edge with data=0 -> RECV, cnt=1; fall_edge with data=1 -> stay IDLE, no error.
  RECV: each fall_edge shifts data in LSB-first, cnt+1; at cnt=10 (stop bit) -> check.
  Check (same cycle): valid iff odd parity over 8 data + parity bit and stop=1. Valid -> byte to decoder; invalid -> error. Always -> IDLE.
  Watchdog: counter cleared on every fall_edge, runs only in RECV; reaching TIMEOUT_CYCLES -> error, IDLE.
- Error: err_pulse=1 for one cycle, err_count+1 saturating at all-ones, prefix flags cleared, nothing enqueued.
- Decoder on valid byte B:
  B=E0 -> ext_pend=1; B=F0 -> brk_pend=1; no event.
  B in {00,AA,EE,FA,FE,FF} (system codes) -> discard, clear both flags.
  Otherwise -> event {B, brk_pend, ext_pend}; enqueue if brk_pend=1 or REPORT_MAKE=1; clear both flags.
- Latency: stop-bit fall_edge in cycle N -> push at end of N; ev_valid=1 from N+1 when FIFO was empty.
- FIFO: first-word-fall-through; ev_valid = not empty; pop when ev_valid & ev_ready; ev_* hold stable while ev_valid=1 and ev_ready=0.
  Full and push, no pop: new event dropped, overflow set (stays 1 until reset).
  Full, push and pop same cycle: both proceed, no overflow.
  Empty and ev_ready=1: no effect.
- Pointers are log2(FIFO_DEPTH)+1 bits; full/empty from MSB-differ compare; wrap is natural.
- Reset mid-frame or mid-handshake: frame, FIFO contents, overflow and err_count all lost.

Decomposition:
- Package ps2_pkg: PS2_EXT=8'hE0, PS2_BRK=8'hF0, system-code constants, PS2_FRAME_BITS=11, event struct {code[7:0], brk, ext} (10 bits).
- Sub-module ps2_event_fifo (parametrised by FIFO_DEPTH and entry width): synchronous FWFT FIFO with full/empty, drop-on-full, overflow flag.

Test Plan:
- Frame 1C (parity 0, stop 1), REPORT_MAKE=1, ev_ready=1 -> one event code=1C brk=0 ext=0, ev_valid one cycle, err_count=0.
- Sequence E0,F0,75 -> exactly one event code=75 brk=1 ext=1; with REPORT_MAKE=0, preceding 75 make produces no event.
- Frame 1C with parity bit flipped, then valid 1C -> err_pulse once, err_count=1, only the second 1C enqueued; F0 before a bad frame does not mark the next byte as break.
- Hold ps2clk high after 5 bits for TIMEOUT_CYCLES -> err_count=1, FSM IDLE; following full frame 2A decodes correctly.
- ev_ready=0, send FIFO_DEPTH+1 make codes 01..09 -> 8 events buffered, overflow=1, drain yields 01..08 in order; push+pop while full -> no additional overflow, order kept.
- Assert reset low during bit 4 and with 3 queued events -> ev_valid=0, overflow=0, err_count=0 immediately; next frame decodes correctly.
